// File: rtl/text_fetch_sequencer.sv
// Character-cell fetch controller for the VGA text path: text RAM -> font ROM -> glyph
// serializer, with a host write port sharing the single text RAM port.
//
// state    | meaning
// IDLE     | no display fetch; host owns the RAM port every cycle
// PREFETCH | 8-cycle lead-in fetching column 0 of the current glyph line
// ACTIVE   | COLS cells of 8 cycles; column c+1 is fetched while column c is shown
module text_fetch_sequencer #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int GLYPH_H = 16,
  parameter int TA_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start_i,
  input  logic                          line_start_i,
  output logic [TA_W-1:0]               txt_addr_o,
  output logic                          txt_we_o,
  output logic [7:0]                    txt_wdata_o,
  input  logic [7:0]                    txt_rdata_i,
  output logic [7+$clog2(GLYPH_H):0]    font_addr_o,
  input  logic [7:0]                    font_data_i,
  input  logic                          host_req_i,
  input  logic [TA_W-1:0]               host_addr_i,
  input  logic [7:0]                    host_data_i,
  output logic                          host_ack_o,
  output logic [7:0]                    charline_o,
  output logic [2:0]                    charpos_x_o,
  output logic                          pix_valid_o
);

  localparam int GL_W  = $clog2(GLYPH_H);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;

  state_t            state_q;
  logic [2:0]        phase_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [GL_W-1:0]   gline_q, gline_d;
  logic              used_q;
  logic              run_q;
  logic [7:0]        code_q;
  logic [7:0]        next_q;
  logic [7:0]        glyph_q;
  logic [7:0]        glyph_d1_q;
  logic [7:0]        charline_q;
  logic [2:0]        act_q;

  logic              line_ok;
  logic              last_cell;
  logic              fetch_en;
  logic              fetch_slot;
  logic              grant;
  logic              host_ok;
  logic [COL_W-1:0]  col_next;
  logic [TA_W-1:0]   fetch_addr;

  // Line counter advances on a line_start only once the previous line has been started.
  always_comb begin
    row_d   = row_q;
    gline_d = gline_q;
    if (frame_start_i) begin
      row_d   = '0;
      gline_d = '0;
    end else if (line_start_i && used_q) begin
      if (gline_q == GL_W'(GLYPH_H - 1)) begin
        gline_d = '0;
        if (row_q < ROW_W'(ROWS)) row_d = row_q + ROW_W'(1);
      end else begin
        gline_d = gline_q + GL_W'(1);
      end
    end
  end

  assign line_ok    = (row_d < ROW_W'(ROWS));
  assign last_cell  = (state_q == ACTIVE) && (col_q == COL_W'(COLS - 1));
  assign fetch_en   = !last_cell;
  assign fetch_slot = (state_q != IDLE) && (phase_q == 3'd0);
  assign col_next   = (state_q == PREFETCH) ? '0 : col_q + COL_W'(1);
  assign fetch_addr = TA_W'(row_q) * TA_W'(COLS) + TA_W'(col_next);

  // run_q keeps the combinational host grant quiet through reset and the cycle after.
  assign grant   = run_q && host_req_i && !fetch_slot;
  assign host_ok = ({1'b0, host_addr_i} < (TA_W + 1)'(COLS * ROWS));

  assign txt_addr_o  = (fetch_slot && fetch_en) ? fetch_addr :
                       grant                    ? host_addr_i : '0;
  assign txt_we_o    = grant && host_ok;
  assign txt_wdata_o = grant ? host_data_i : 8'd0;
  assign host_ack_o  = grant;
  assign font_addr_o = ((state_q != IDLE) && (phase_q == 3'd2) && fetch_en) ?
                       {code_q, gline_q} : '0;
  assign charpos_x_o = (state_q == ACTIVE) ? phase_q : 3'd0;
  assign charline_o  = charline_q;
  assign pix_valid_o = act_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      gline_q    <= '0;
      used_q     <= 1'b0;
      run_q      <= 1'b0;
      code_q     <= '0;
      next_q     <= '0;
      glyph_q    <= '0;
      glyph_d1_q <= '0;
      charline_q <= '0;
      act_q      <= '0;
    end else begin
      run_q      <= 1'b1;
      row_q      <= row_d;
      gline_q    <= gline_d;
      glyph_d1_q <= glyph_q;
      charline_q <= glyph_d1_q;
      act_q      <= {act_q[1:0], (state_q == ACTIVE)};

      if (line_start_i)       used_q <= 1'b1;
      else if (frame_start_i) used_q <= 1'b0;

      if (line_start_i) begin
        // Abort/restart: flush everything downstream so no stale glyph reaches the serializer.
        state_q    <= line_ok ? PREFETCH : IDLE;
        phase_q    <= '0;
        col_q      <= '0;
        code_q     <= '0;
        next_q     <= '0;
        glyph_q    <= '0;
        glyph_d1_q <= '0;
        charline_q <= '0;
        act_q      <= '0;
      end else begin
        case (state_q)
          IDLE: phase_q <= '0;
          default: begin
            phase_q <= phase_q + 3'd1;
            if (fetch_en && (phase_q == 3'd1)) code_q <= txt_rdata_i;
            if (fetch_en && (phase_q == 3'd3)) next_q <= font_data_i;
            if (phase_q == 3'd7) begin
              if (state_q == PREFETCH) begin
                state_q <= ACTIVE;
                col_q   <= '0;
                glyph_q <= next_q;
              end else if (last_cell) begin
                state_q <= IDLE;
                col_q   <= '0;
                glyph_q <= '0;
              end else begin
                col_q   <= col_q + COL_W'(1);
                glyph_q <= next_q;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
